// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin share of the GPR write port and CR0 port between FX and LS
module writeback_arbiter #(
    parameter int regWidth  = 5,
    parameter int dataWidth = 64,
    parameter int fifoDepth = 4,
    parameter int ptrWidth  = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 fxValid_i,
    input  logic                 fxRegWriteEnable_i,
    input  logic [regWidth-1:0]  fxRegAddress_i,
    input  logic [dataWidth-1:0] fxRegValue_i,
    input  logic                 fxCRUpdateEnable_i,
    input  logic [3:0]           fxCR0_i,
    output logic                 fxStall_o,
    input  logic                 lsValid_i,
    input  logic                 lsReg1Enable_i,
    input  logic                 lsReg2Enable_i,
    input  logic [regWidth-1:0]  lsReg1Address_i,
    input  logic [regWidth-1:0]  lsReg2Address_i,
    input  logic [dataWidth-1:0] lsReg1Value_i,
    input  logic [dataWidth-1:0] lsReg2Value_i,
    output logic                 lsStall_o,
    output logic                 wbEnable_o,
    output logic [regWidth-1:0]  wbAddress_o,
    output logic [dataWidth-1:0] wbValue_o,
    output logic [2:0]           wbUnitCode_o,
    output logic                 crEnable_o,
    output logic [3:0]           crVal_o
);
    localparam int CW = ptrWidth + 1;
    typedef struct packed {
        logic                 we;
        logic [regWidth-1:0]  addr;
        logic [dataWidth-1:0] val;
        logic                 ce;
        logic [3:0]           cr;
    } fx_t;
    typedef struct packed {
        logic                 e1;
        logic [regWidth-1:0]  a1;
        logic [dataWidth-1:0] v1;
        logic                 e2;
        logic [regWidth-1:0]  a2;
        logic [dataWidth-1:0] v2;
    } ls_t;
    typedef enum logic {IDLE, SECOND} state_t;
    fx_t fx_mem [fifoDepth];
    ls_t ls_mem [fifoDepth];
    fx_t fx_head;
    ls_t ls_head;
    logic [ptrWidth-1:0] fx_rd, fx_wr, ls_rd, ls_wr;
    logic [CW-1:0] fx_cnt, ls_cnt, fx_cnt_n, ls_cnt_n;
    state_t state, state_n;
    logic last_ls, fx_push, ls_push, fx_acc, ls_acc, fx_pop, ls_pop;
    logic grant_fx, grant_ls, ls_any, use_r1, ls_dual;
    logic wb_en_n, cr_en_n;
    logic [regWidth-1:0] wb_addr_n;
    logic [dataWidth-1:0] wb_val_n;
    logic [2:0] code_n;
    logic [3:0] cr_n;

    assign fx_head  = fx_mem[fx_rd];
    assign ls_head  = ls_mem[ls_rd];
    assign fx_push  = fxValid_i && (fxRegWriteEnable_i || fxCRUpdateEnable_i);
    assign ls_push  = lsValid_i && (lsReg1Enable_i || lsReg2Enable_i);
    assign fx_acc   = fx_push && (fx_cnt != CW'(fifoDepth) || fx_pop);
    assign ls_acc   = ls_push && (ls_cnt != CW'(fifoDepth) || ls_pop);
    assign fx_cnt_n = fx_cnt + CW'(fx_acc) - CW'(fx_pop);
    assign ls_cnt_n = ls_cnt + CW'(ls_acc) - CW'(ls_pop);
    assign ls_dual  = ls_head.e1 && ls_head.e2;

    // Grant selection, pops, next state and the next output word
    always_comb begin
        grant_fx  = state == IDLE && fx_cnt != '0 && (ls_cnt == '0 || last_ls);
        grant_ls  = state == IDLE && ls_cnt != '0 && !grant_fx;
        ls_any    = grant_ls || state == SECOND;
        use_r1    = grant_ls && ls_head.e1;
        fx_pop    = grant_fx;
        ls_pop    = state == SECOND || (grant_ls && !ls_dual);
        state_n   = grant_ls && ls_dual ? SECOND : IDLE;
        wb_en_n   = grant_fx ? fx_head.we : ls_any;
        wb_addr_n = grant_fx ? fx_head.addr : use_r1 ? ls_head.a1 : ls_any ? ls_head.a2 : '0;
        wb_val_n  = grant_fx ? fx_head.val : use_r1 ? ls_head.v1 : ls_any ? ls_head.v2 : '0;
        code_n    = ls_any ? 3'd2 : 3'd0;
        cr_en_n   = grant_fx && fx_head.ce;
        cr_n      = grant_fx ? fx_head.cr : 4'd0;
    end

    // FSM state and round-robin pointer; pointer holds through the LS second write
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state   <= IDLE;
            last_ls <= 1'b1;
        end else begin
            state   <= state_n;
            last_ls <= grant_ls || (last_ls && !grant_fx);
        end
    end

    // Per-source FIFOs; a push into a full FIFO is dropped unless a pop frees a slot
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            fx_rd  <= '0;
            fx_wr  <= '0;
            fx_cnt <= '0;
            ls_rd  <= '0;
            ls_wr  <= '0;
            ls_cnt <= '0;
        end else begin
            if (fx_acc) begin
                fx_mem[fx_wr] <= {fxRegWriteEnable_i, fxRegAddress_i, fxRegValue_i, fxCRUpdateEnable_i, fxCR0_i};
                fx_wr         <= fx_wr + ptrWidth'(1);
            end
            if (ls_acc) begin
                ls_mem[ls_wr] <= {lsReg1Enable_i, lsReg1Address_i, lsReg1Value_i, lsReg2Enable_i, lsReg2Address_i, lsReg2Value_i};
                ls_wr         <= ls_wr + ptrWidth'(1);
            end
            if (fx_pop) fx_rd <= fx_rd + ptrWidth'(1);
            if (ls_pop) ls_rd <= ls_rd + ptrWidth'(1);
            fx_cnt <= fx_cnt_n;
            ls_cnt <= ls_cnt_n;
        end
    end

    // Registered write-port outputs and stalls (stall keeps one slot for an in-flight result)
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wbEnable_o   <= 1'b0;
            wbAddress_o  <= '0;
            wbValue_o    <= '0;
            wbUnitCode_o <= 3'd0;
            crEnable_o   <= 1'b0;
            crVal_o      <= 4'd0;
            fxStall_o    <= 1'b0;
            lsStall_o    <= 1'b0;
        end else begin
            wbEnable_o   <= wb_en_n;
            wbAddress_o  <= wb_addr_n;
            wbValue_o    <= wb_val_n;
            wbUnitCode_o <= code_n;
            crEnable_o   <= cr_en_n;
            crVal_o      <= cr_n;
            fxStall_o    <= fx_cnt_n >= CW'(fifoDepth - 1);
            lsStall_o    <= ls_cnt_n >= CW'(fifoDepth - 1);
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        fxValid_i, fxRegWriteEnable_i, fxCRUpdateEnable_i;
    logic [4:0]  fxRegAddress_i;
    logic [63:0] fxRegValue_i;
    logic [3:0]  fxCR0_i;
    logic        fxStall_o;
    logic        lsValid_i, lsReg1Enable_i, lsReg2Enable_i;
    logic [4:0]  lsReg1Address_i, lsReg2Address_i;
    logic [63:0] lsReg1Value_i, lsReg2Value_i;
    logic        lsStall_o;
    logic        wbEnable_o, crEnable_o;
    logic [4:0]  wbAddress_o;
    logic [63:0] wbValue_o;
    logic [2:0]  wbUnitCode_o;
    logic [3:0]  crVal_o;
    int passed = 0;
    int failed = 0;
    int total = 0;
    logic [77:0] exp_c [13];

    writeback_arbiter dut (
        .clock_i(clk), .reset_i(reset_i),
        .fxValid_i(fxValid_i), .fxRegWriteEnable_i(fxRegWriteEnable_i),
        .fxRegAddress_i(fxRegAddress_i), .fxRegValue_i(fxRegValue_i),
        .fxCRUpdateEnable_i(fxCRUpdateEnable_i), .fxCR0_i(fxCR0_i), .fxStall_o(fxStall_o),
        .lsValid_i(lsValid_i), .lsReg1Enable_i(lsReg1Enable_i), .lsReg2Enable_i(lsReg2Enable_i),
        .lsReg1Address_i(lsReg1Address_i), .lsReg2Address_i(lsReg2Address_i),
        .lsReg1Value_i(lsReg1Value_i), .lsReg2Value_i(lsReg2Value_i), .lsStall_o(lsStall_o),
        .wbEnable_o(wbEnable_o), .wbAddress_o(wbAddress_o), .wbValue_o(wbValue_o),
        .wbUnitCode_o(wbUnitCode_o), .crEnable_o(crEnable_o), .crVal_o(crVal_o)
    );

    always #5 clk = ~clk;

    function automatic logic [77:0] pk(logic en, logic [4:0] a, logic [63:0] v, logic [2:0] c, logic ce, logic [3:0] cr);
        return {en, a, v, c, ce, cr};
    endfunction

    function automatic logic [77:0] fxo(int n);
        return pk(1'b1, 5'(n), 64'(32'hF0 + n), 3'd0, 1'b1, 4'(n));
    endfunction

    function automatic logic [77:0] lso(int a, int v);
        return pk(1'b1, 5'(a), 64'(v), 3'd2, 1'b0, 4'd0);
    endfunction

    function automatic logic [77:0] outs();
        return {wbEnable_o, wbAddress_o, wbValue_o, wbUnitCode_o, crEnable_o, crVal_o};
    endfunction

    function automatic logic [77:0] stalls();
        return 78'({fxStall_o, lsStall_o});
    endfunction

    task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fx(input logic v, input logic we, input int a, input int d, input logic ce, input int c);
        fxValid_i = v; fxRegWriteEnable_i = we; fxRegAddress_i = 5'(a);
        fxRegValue_i = 64'(d); fxCRUpdateEnable_i = ce; fxCR0_i = 4'(c);
    endtask

    task automatic ls(input logic v, input logic e1, input int a1, input int d1, input logic e2, input int a2, input int d2);
        lsValid_i = v; lsReg1Enable_i = e1; lsReg1Address_i = 5'(a1); lsReg1Value_i = 64'(d1);
        lsReg2Enable_i = e2; lsReg2Address_i = 5'(a2); lsReg2Value_i = 64'(d2);
    endtask

    task automatic idle_in();
        fx(0, 0, 0, 0, 0, 0);
        ls(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle_in();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
    endtask

    initial begin
        // Reset held two cycles with FX valid: nothing enqueued, outputs zero
        idle_in();
        reset_i = 1'b0;
        fx(1, 1, 9, 'h99, 1, 3);
        tick();
        tick();
        chk("reset_out", outs(), '0);
        chk("reset_stall", stalls(), '0);
        reset_i = 1'b1;
        idle_in();
        tick();
        chk("post_reset_empty", outs(), '0);
        fx(1, 1, 3, 'h55, 1, 4'b0100);
        tick();
        chk("no_bypass", outs(), '0);
        idle_in();
        tick();
        chk("fx_first", outs(), pk(1, 3, 64'h55, 0, 1, 4'b0100));
        tick();
        chk("idle_after_fx", outs(), '0);

        // Simultaneous single FX / LS pushes alternate FX first
        do_reset();
        for (int j = 0; j < 10; j++) begin
            if (j < 4) begin
                fx(1, 1, 1 + j, 'h100 + j, 0, 0);
                ls(1, 1, 11 + j, 'h200 + j, 0, 0, 0);
            end else idle_in();
            tick();
            if (j >= 1 && j <= 8)
                chk($sformatf("alt_%0d", j), outs(),
                    (j % 2 == 1) ? pk(1, 5'(1 + (j - 1) / 2), 64'('h100 + (j - 1) / 2), 0, 0, 0)
                                 : lso(11 + j / 2 - 1, 'h200 + j / 2 - 1));
            if (j == 3) chk("alt_stall", stalls(), 78'(2'b01));
            if (j == 9) chk("alt_drain", outs(), '0);
        end

        // Dual LS writes, FX stall and a dropped push into a full FX FIFO
        do_reset();
        exp_c[0]  = fxo(1);
        exp_c[1]  = lso(5, 'hA);
        exp_c[2]  = lso(6, 'hB);
        exp_c[3]  = fxo(2);
        exp_c[4]  = lso(8, 'hC);
        exp_c[5]  = lso(9, 'hD);
        exp_c[6]  = fxo(3);
        exp_c[7]  = lso(11, 'hE);
        exp_c[8]  = lso(12, 'hF);
        exp_c[9]  = fxo(4);
        exp_c[10] = fxo(5);
        exp_c[11] = fxo(6);
        exp_c[12] = '0;
        for (int j = 0; j < 14; j++) begin
            if (j < 7) fx(1, 1, j + 1, 'hF0 + j + 1, 1, j + 1);
            else fx(0, 0, 0, 0, 0, 0);
            if (j < 3) ls(1, 1, 5 + 3 * j, 'hA + 2 * j, 1, 6 + 3 * j, 'hB + 2 * j);
            else ls(0, 0, 0, 0, 0, 0, 0);
            tick();
            if (j >= 1) chk($sformatf("dual_%0d", j), outs(), exp_c[j - 1]);
            if (j == 2) chk("dual_stall_e2", stalls(), 78'(2'b01));
            if (j == 3) chk("dual_stall_e3", stalls(), 78'(2'b10));
            if (j == 6) chk("dual_stall_e6", stalls(), 78'(2'b10));
            if (j == 10) chk("dual_stall_e10", stalls(), '0);
        end

        // Five back-to-back FX pushes drain in order
        do_reset();
        for (int j = 0; j < 7; j++) begin
            if (j < 5) fx(1, 1, 20 + j, 'h300 + j, 0, 0);
            else idle_in();
            tick();
            if (j >= 1 && j <= 5)
                chk($sformatf("fx5_%0d", j), outs(), pk(1, 5'(20 + j - 1), 64'('h300 + j - 1), 0, 0, 0));
            if (j == 6) chk("fx5_drain", outs(), '0);
        end

        // Reset during the second half of a dual write cancels reg2
        do_reset();
        ls(1, 1, 5, 'hA, 1, 6, 'hB);
        tick();
        idle_in();
        tick();
        chk("sec_r1", outs(), lso(5, 'hA));
        reset_i = 1'b0;
        tick();
        chk("sec_reset", outs(), '0);
        reset_i = 1'b1;
        tick();
        chk("sec_after1", outs(), '0);
        tick();
        chk("sec_after2", outs(), '0);
        chk("sec_stall", stalls(), '0);

        // Valid with no enables ignored; LS reg2-only; FX CR-only
        do_reset();
        fx(1, 0, 4, 'h44, 0, 1);
        ls(1, 0, 4, 'h44, 0, 5, 'h45);
        tick();
        idle_in();
        tick();
        chk("no_enable", outs(), '0);
        ls(1, 0, 1, 'h11, 1, 9, 'h99);
        tick();
        idle_in();
        tick();
        chk("ls_reg2_only", outs(), lso(9, 'h99));
        fx(1, 0, 7, 'h77, 1, 4'b1010);
        tick();
        idle_in();
        tick();
        chk("fx_cr_only", outs(), pk(0, 7, 64'h77, 0, 1, 4'b1010));
        tick();
        chk("final_idle", outs(), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
